// File: rtl/fixedpoint_pkg.sv
// Shared Q6.9 fixed-point definitions: widths, saturation limits, divider state
// encoding and the result saturation helper.
package fixedpoint_pkg;

  localparam int unsigned WIDTH_INPUT    = 16;
  localparam int unsigned WIDTH_FRACTION = 9;
  localparam int unsigned WIDTH_NUM      = WIDTH_INPUT + WIDTH_FRACTION;

  localparam logic [WIDTH_INPUT-1:0] Q69_MAX = 16'h7FFF;
  localparam logic [WIDTH_INPUT-1:0] Q69_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic                   overflow;
    logic [WIDTH_INPUT-1:0] value;
  } sat_t;

  // Map an unsigned quotient magnitude plus sign onto the signed Q6.9 range.
  function automatic sat_t saturate_q69(input logic [WIDTH_NUM-1:0] mag,
                                        input logic                 neg);
    sat_t r;
    r.overflow = 1'b0;
    r.value    = '0;
    if (!neg && (mag > WIDTH_NUM'(Q69_MAX))) begin
      r.overflow = 1'b1;
      r.value    = Q69_MAX;
    end else if (neg && (mag > WIDTH_NUM'(Q69_MIN))) begin
      r.overflow = 1'b1;
      r.value    = Q69_MIN;
    end else if (neg) begin
      r.value = ~mag[WIDTH_INPUT-1:0] + WIDTH_INPUT'(1);
    end else begin
      r.value = mag[WIDTH_INPUT-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fixedpoint_divider_if.sv
// Operand/result handshake bundle for the Q6.9 divider.
interface fixedpoint_divider_if #(
  parameter int unsigned WIDTH_INPUT = fixedpoint_pkg::WIDTH_INPUT
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH_INPUT-1:0] dividend;
  logic [WIDTH_INPUT-1:0] divisor;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH_INPUT-1:0] quotient;
  logic                   overflow;
  logic                   div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, overflow, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, overflow, div_zero
  );
endinterface

// File: rtl/fixedpoint_divider.sv
// Signed Q6.9 divider: sequential radix-2 restoring division on magnitudes,
// fixed 26-cycle latency, saturating result and divide-by-zero flag.
module fixedpoint_divider #(
  parameter int unsigned WIDTH_INPUT    = fixedpoint_pkg::WIDTH_INPUT,
  parameter int unsigned WIDTH_FRACTION = fixedpoint_pkg::WIDTH_FRACTION
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WIDTH_INPUT-1:0] dividend_i,
  input  logic [WIDTH_INPUT-1:0] divisor_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WIDTH_INPUT-1:0] quotient_o,
  output logic                   overflow_o,
  output logic                   div_zero_o
);
  import fixedpoint_pkg::*;

  localparam int unsigned WIDTH_DIV = WIDTH_INPUT + WIDTH_FRACTION;
  localparam int unsigned WIDTH_REM = WIDTH_INPUT + 1;
  localparam int unsigned WIDTH_CNT = $clog2(WIDTH_DIV + 1);
  localparam logic [WIDTH_CNT-1:0] LAST_STEP = WIDTH_CNT'(WIDTH_DIV);

  state_e                 state_q, state_d;
  logic [WIDTH_CNT-1:0]   cnt_q, cnt_d;
  logic [WIDTH_DIV-1:0]   num_q, num_d;
  logic [WIDTH_INPUT-1:0] rem_q, rem_d;
  logic [WIDTH_INPUT-1:0] dvs_q, dvs_d;
  logic                   neg_q, neg_d;
  logic                   zdiv_q, zdiv_d;
  logic [WIDTH_INPUT-1:0] quotient_q, quotient_d;
  logic                   overflow_q, overflow_d;
  logic                   div_zero_q, div_zero_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;

  logic [WIDTH_REM-1:0]   rem_shift;
  logic                   q_bit;
  logic [WIDTH_INPUT-1:0] abs_dividend;
  logic [WIDTH_INPUT-1:0] abs_divisor;
  sat_t                   sat;

  // Next-state, datapath step and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    neg_d       = neg_q;
    zdiv_d      = zdiv_q;
    quotient_d  = quotient_q;
    overflow_d  = overflow_q;
    div_zero_d  = div_zero_q;

    abs_dividend = dividend_i[WIDTH_INPUT-1] ? (~dividend_i + WIDTH_INPUT'(1)) : dividend_i;
    abs_divisor  = divisor_i[WIDTH_INPUT-1]  ? (~divisor_i  + WIDTH_INPUT'(1)) : divisor_i;
    rem_shift    = {rem_q, num_q[WIDTH_DIV-1]};
    q_bit        = (rem_shift >= {1'b0, dvs_q});
    sat          = saturate_q69(num_q, neg_q);

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = CALC;
          rem_d   = '0;
          dvs_d   = abs_divisor;
          num_d   = {abs_dividend, WIDTH_FRACTION'(0)};
          if (divisor_i == '0) begin
            // Zero divisor skips the iterations and lands on the finalize cycle.
            zdiv_d = 1'b1;
            neg_d  = dividend_i[WIDTH_INPUT-1];
            cnt_d  = LAST_STEP;
          end else begin
            zdiv_d = 1'b0;
            neg_d  = dividend_i[WIDTH_INPUT-1] ^ divisor_i[WIDTH_INPUT-1];
            cnt_d  = '0;
          end
        end
      end
      CALC: begin
        if (cnt_q == LAST_STEP) begin
          state_d    = DONE;
          div_zero_d = zdiv_q;
          if (zdiv_q) begin
            quotient_d = neg_q ? Q69_MIN : Q69_MAX;
            overflow_d = 1'b0;
          end else begin
            quotient_d = sat.value;
            overflow_d = sat.overflow;
          end
        end else begin
          rem_d = q_bit ? WIDTH_INPUT'(rem_shift - {1'b0, dvs_q})
                        : rem_shift[WIDTH_INPUT-1:0];
          num_d = {num_q[WIDTH_DIV-2:0], q_bit};
          cnt_d = cnt_q + WIDTH_CNT'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      num_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      neg_q       <= 1'b0;
      zdiv_q      <= 1'b0;
      quotient_q  <= '0;
      overflow_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      neg_q       <= neg_d;
      zdiv_q      <= zdiv_d;
      quotient_q  <= quotient_d;
      overflow_q  <= overflow_d;
      div_zero_q  <= div_zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign quotient_o  = quotient_q;
  assign overflow_o  = overflow_q;
  assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_fixedpoint_divider.sv
// Directed-vector bench for the Q6.9 divider: results, latency, saturation,
// divide-by-zero, back-pressure and reset abort.
module tb_fixedpoint_divider;
  import fixedpoint_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fixedpoint_divider_if ifc ();

  fixedpoint_divider dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (ifc.in_valid),
    .in_ready_o  (ifc.in_ready),
    .dividend_i  (ifc.dividend),
    .divisor_i   (ifc.divisor),
    .out_valid_o (ifc.out_valid),
    .out_ready_i (ifc.out_ready),
    .quotient_o  (ifc.quotient),
    .overflow_o  (ifc.overflow),
    .div_zero_o  (ifc.div_zero)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands for one cycle; returns after the accept edge (+1).
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.dividend = a;
    ifc.divisor  = b;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.dividend = 16'($urandom);
    ifc.divisor  = 16'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!ifc.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    expect_eq({tag, "_idle"}, {ifc.in_ready, ifc.out_valid}, 2'b10);
  endtask

  task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic eo, input logic ez, input int elat);
    int lat;
    expect_eq({tag, "_rdy"}, ifc.in_ready, 1'b1);
    start_op(a, b);
    wait_valid(lat);
    expect_eq({tag, "_lat"}, lat, elat);
    expect_eq({tag, "_q"}, ifc.quotient, eq);
    expect_eq({tag, "_flags"}, {ifc.overflow, ifc.div_zero}, {eo, ez});
    release_result(tag);
  endtask

  initial begin
    int lat;
    int seen;
    ifc.in_valid  = 1'b0;
    ifc.dividend  = '0;
    ifc.divisor   = '0;
    ifc.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    expect_eq("reset_state",
              {ifc.in_ready, ifc.out_valid, ifc.quotient, ifc.overflow, ifc.div_zero},
              {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
    @(negedge clk) rst_n = 1'b1;

    run_vec("p1p5_div_0p5",  16'h0300, 16'h0100, 16'h0600, 1'b0, 1'b0, 26);
    run_vec("neg_div_pos",   16'hFD00, 16'h0100, 16'hFA00, 1'b0, 1'b0, 26);
    run_vec("trunc_pos",     16'h0200, 16'h0600, 16'h00AA, 1'b0, 1'b0, 26);
    run_vec("trunc_neg",     16'hFE00, 16'h0600, 16'hFF56, 1'b0, 1'b0, 26);
    run_vec("sat_pos",       16'h4000, 16'h0020, 16'h7FFF, 1'b1, 1'b0, 26);
    run_vec("min_div_m1",    16'h8000, 16'hFE00, 16'h7FFF, 1'b1, 1'b0, 26);
    run_vec("min_exact",     16'h8000, 16'h0200, 16'h8000, 1'b0, 1'b0, 26);
    run_vec("neg_to_zero",   16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 26);
    run_vec("max_div_max",   16'h7FFF, 16'h7FFF, 16'h0200, 1'b0, 1'b0, 26);
    run_vec("min_div_min",   16'h8000, 16'h8000, 16'h0200, 1'b0, 1'b0, 26);
    run_vec("lsb_div_one",   16'hFFFF, 16'h0200, 16'hFFFF, 1'b0, 1'b0, 26);
    run_vec("dz_neg",        16'hFD00, 16'h0000, 16'h8000, 1'b0, 1'b1, 1);
    run_vec("dz_zero",       16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1);

    // Back-pressure: result holds, no accept while DONE.
    start_op(16'h0300, 16'h0100);
    wait_valid(lat);
    expect_eq("stall_lat", lat, 26);
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.dividend = 16'h0200;
    ifc.divisor  = 16'h0100;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      expect_eq("stall_hold",
                {ifc.out_valid, ifc.in_ready, ifc.quotient, ifc.overflow, ifc.div_zero},
                {1'b1, 1'b0, 16'h0600, 1'b0, 1'b0});
    end
    @(negedge clk) ifc.in_valid = 1'b0;
    release_result("stall");
    @(posedge clk); #1;
    expect_eq("stall_no_accept", {ifc.in_ready, ifc.out_valid}, 2'b10);

    // Reset at cycle 10 of CALC aborts with nothing presented.
    start_op(16'h0300, 16'h0100);
    repeat (9) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    expect_eq("abort_reset",
              {ifc.in_ready, ifc.out_valid, ifc.quotient, ifc.overflow, ifc.div_zero},
              {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (ifc.out_valid) seen++;
    end
    expect_eq("abort_no_result", seen, 0);
    run_vec("after_abort", 16'hFE00, 16'h0600, 16'hFF56, 1'b0, 1'b0, 26);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
